pipeline_frontend_ctrl: RTL and testbench

PIPELINE_FRONTEND_CTRL -- requirements
Module: pipeline_frontend_ctrl

---
 rtl/pipeline_frontend_ctrl_pkg.sv | 34 +++
 rtl/pipeline_frontend_ctrl_if.sv | 65 ++++++
 rtl/pipeline_frontend_ctrl_fwd_unit.sv | 28 ++
 rtl/pipeline_frontend_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pipeline_frontend_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_frontend_ctrl_pkg.sv
// Shared types and constants for the pipeline front end.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package pipeline_pkg;

  localparam int PC_W   = 8;
  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  localparam logic [DATA_W-1:0] NOP = 16'h0000;

  // Front-end FSM states. The numeric values are visible on state_out.
  typedef enum logic [1:0] {
    FE_RUN   = 2'd0,
    FE_STALL = 2'd1,
    FE_FLUSH = 2'd2,
    FE_HALT  = 2'd3
  } fe_state_e;

  // A pending register write from a later stage, used as a bypass source.
  typedef struct packed {
    logic              vld;
    logic [REG_W-1:0]  num;
    logic [DATA_W-1:0] dat;
  } wb_src_t;

  // True when register number n names either of two source operands.
  function automatic logic src_match(input logic [REG_W-1:0] n,
                                     input logic [REG_W-1:0] a,
                                     input logic [REG_W-1:0] b);
    return (n == a) || (n == b);
  endfunction

endpackage

// File: rtl/pipeline_frontend_ctrl_if.sv
// Bundle of fetch, hazard, bypass and control signals between the front end and the pipe.
// Latency: none (wires only).
// Backpressure: none; stalls are signalled through update_1out / rst_p_out.
interface pipeline_frontend_ctrl_if;
  import pipeline_pkg::*;

  // fetch
  logic [PC_W-1:0]   imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  // decode hand-off
  logic [DATA_W-1:0] IR_out;
  logic [PC_W-1:0]   PC_out;
  logic              update_1out;
  logic [4:1]        rst_p_out;
  // S1 sources / S2 destination
  logic [REG_W-1:0]  num_Rm_1in;
  logic [REG_W-1:0]  num_Rn_1in;
  logic [REG_W-1:0]  num_Rd_2in;
  logic              loads_2in;
  // S2 register-file values
  logic [REG_W-1:0]  num_Rm_2in;
  logic [REG_W-1:0]  num_Rn_2in;
  logic [DATA_W-1:0] data_Rm_2in;
  logic [DATA_W-1:0] data_Rn_2in;
  logic [DATA_W-1:0] data_Rd_2in;
  // S3 result and S4 writeback
  logic [DATA_W-1:0] result_3in;
  logic [REG_W-1:0]  writenum_3in;
  logic              write_3in;
  logic [DATA_W-1:0] writeback_data_in;
  logic [REG_W-1:0]  writenum_in;
  logic              write_in;
  // bypassed operands
  logic [DATA_W-1:0] data_fRm_2out;
  logic [DATA_W-1:0] data_fRn_2out;
  logic [DATA_W-1:0] data_fRd_3out;
  // control flow
  logic              branch_taken_in;
  logic [PC_W-1:0]   branch_target_in;
  logic              halt_in;
  logic [1:0]        state_out;

  // The front-end controller.
  modport master (
    output imem_addr, IR_out, PC_out, update_1out, rst_p_out,
           data_fRm_2out, data_fRn_2out, data_fRd_3out, state_out,
    input  imem_rdata, num_Rm_1in, num_Rn_1in, num_Rd_2in, loads_2in,
           num_Rm_2in, num_Rn_2in, data_Rm_2in, data_Rn_2in, data_Rd_2in,
           result_3in, writenum_3in, write_3in,
           writeback_data_in, writenum_in, write_in,
           branch_taken_in, branch_target_in, halt_in
  );

  // The rest of the pipeline (memory, register file, later stages).
  modport slave (
    input  imem_addr, IR_out, PC_out, update_1out, rst_p_out,
           data_fRm_2out, data_fRn_2out, data_fRd_3out, state_out,
    output imem_rdata, num_Rm_1in, num_Rn_1in, num_Rd_2in, loads_2in,
           num_Rm_2in, num_Rn_2in, data_Rm_2in, data_Rn_2in, data_Rd_2in,
           result_3in, writenum_3in, write_3in,
           writeback_data_in, writenum_in, write_in,
           branch_taken_in, branch_target_in, halt_in
  );

endinterface

// File: rtl/pipeline_frontend_ctrl_fwd_unit.sv
// Operand bypass mux: picks the youngest pending write to the operand's register.
// Latency: combinational, zero cycles.
// Backpressure: none.
module pipeline_fwd_unit
  import pipeline_pkg::*;
#(
  parameter bit EN = 1'b1
) (
  input  logic [REG_W-1:0]  num_i,
  input  logic [DATA_W-1:0] dat_i,
  input  wb_src_t           s3_i,
  input  wb_src_t           s4_i,
  output logic [DATA_W-1:0] dat_o
);

  // S3 is younger than S4, so it wins when both target the same register.
  always_comb begin
    dat_o = dat_i;
    if (EN) begin
      if (s3_i.vld && (s3_i.num == num_i)) begin
        dat_o = s3_i.dat;
      end else if (s4_i.vld && (s4_i.num == num_i)) begin
        dat_o = s4_i.dat;
      end
    end
  end

endmodule

// File: rtl/pipeline_frontend_ctrl.sv
// Fetch/PC control with load-use stall, branch flush, halt and operand bypass (FRONTEND_FWD_EN).
// Latency: PC/IR update one cycle; bypass outputs combinational.
// Backpressure: hazards hold PC/IR and drop update_1out; rst_p_out injects bubbles per stage.
module pipeline_frontend_ctrl
  import pipeline_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  pipeline_frontend_ctrl_if.master bus
);

`ifdef FRONTEND_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  localparam logic [1:0] S_RUN   = FE_RUN;
  localparam logic [1:0] S_STALL = FE_STALL;
  localparam logic [1:0] S_FLUSH = FE_FLUSH;
  localparam logic [1:0] S_HALT  = FE_HALT;

  logic [1:0]        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [PC_W-1:0]   pcout_q, pcout_d;
  logic [REG_W-1:0]  rd_num_q;
  logic [DATA_W-1:0] rd_dat_q;
  logic [DATA_W-1:0] rd_fwd;
  logic [4:1]        rst_p;
  logic              load_use;
  logic              pending_hit;
  logic              hazard;
  wb_src_t           s3_src;
  wb_src_t           s4_src;

  assign s3_src = '{vld: bus.write_3in, num: bus.writenum_3in, dat: bus.result_3in};
  assign s4_src = '{vld: bus.write_in,  num: bus.writenum_in,  dat: bus.writeback_data_in};

  // Hazard detection. Without bypassing, any S1 source that an older
  // instruction is still going to write must wait until that write lands.
  always_comb begin
    load_use    = bus.loads_2in &
                  src_match(bus.num_Rd_2in, bus.num_Rm_1in, bus.num_Rn_1in);
    pending_hit = src_match(bus.num_Rd_2in, bus.num_Rm_1in, bus.num_Rn_1in) |
                  (bus.write_3in &
                   src_match(bus.writenum_3in, bus.num_Rm_1in, bus.num_Rn_1in));
    hazard      = load_use | (!FWD_EN & pending_hit);
  end

  // Next-state selection: branch beats stall beats halt beats normal advance.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (bus.branch_taken_in)  state_d = S_FLUSH;
        else if (hazard)          state_d = S_STALL;
        else if (bus.halt_in)     state_d = S_HALT;
        else                      state_d = S_RUN;
      end
      S_STALL: begin
        // With bypassing a single bubble resolves a load-use; without it the
        // stall repeats while the dependency is still outstanding.
        if (bus.branch_taken_in)      state_d = S_FLUSH;
        else if (hazard && !FWD_EN)   state_d = S_STALL;
        else if (bus.halt_in)         state_d = S_HALT;
        else                          state_d = S_RUN;
      end
      S_FLUSH: begin
        if (bus.halt_in) state_d = S_HALT;
        else             state_d = S_RUN;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RUN;
    endcase
  end

  // Fetch registers follow the state being entered: advance into RUN,
  // redirect into FLUSH, hold into STALL or HALT.
  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    pcout_d = pcout_q;
    case (state_d)
      S_RUN: begin
        pc_d    = pc_q + 1'b1;
        ir_d    = bus.imem_rdata;
        pcout_d = pc_q;
      end
      S_FLUSH: begin
        pc_d = bus.branch_target_in;
        ir_d = NOP;
      end
      default: begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        pcout_d = pcout_q;
      end
    endcase
  end

  // Per-stage bubble controls; a flush clears S1..S3.
  always_comb begin
    rst_p = 4'b0000;
    if (rst) begin
      rst_p = 4'b1111;
    end else begin
      case (state_q)
        S_STALL: rst_p = 4'b0010;
        S_FLUSH: rst_p = 4'b0111;
        S_HALT:  rst_p = 4'b0001;
        default: rst_p = 4'b0000;
      endcase
    end
  end

  // FSM and fetch state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      pc_q    <= '0;
      ir_q    <= NOP;
      pcout_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      pcout_q <= pcout_d;
    end
  end

  pipeline_fwd_unit #(.EN(FWD_EN)) u_fwd_rm (
    .num_i (bus.num_Rm_2in),
    .dat_i (bus.data_Rm_2in),
    .s3_i  (s3_src),
    .s4_i  (s4_src),
    .dat_o (bus.data_fRm_2out)
  );

  pipeline_fwd_unit #(.EN(FWD_EN)) u_fwd_rn (
    .num_i (bus.num_Rn_2in),
    .dat_i (bus.data_Rn_2in),
    .s3_i  (s3_src),
    .s4_i  (s4_src),
    .dat_o (bus.data_fRn_2out)
  );

  // Store data for the instruction moving into S3 gets the same bypass.
  pipeline_fwd_unit #(.EN(FWD_EN)) u_fwd_rd (
    .num_i (bus.num_Rd_2in),
    .dat_i (bus.data_Rd_2in),
    .s3_i  (s3_src),
    .s4_i  (s4_src),
    .dat_o (rd_fwd)
  );

  // S3 store-data register, emptied whenever S3 is being flushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_num_q <= '0;
      rd_dat_q <= '0;
    end else if (rst_p[3]) begin
      rd_num_q <= '0;
      rd_dat_q <= '0;
    end else begin
      rd_num_q <= bus.num_Rd_2in;
      rd_dat_q <= rd_fwd;
    end
  end

  // A writeback landing this cycle is newer than the value captured last cycle.
  assign bus.data_fRd_3out = (FWD_EN && bus.write_in && (bus.writenum_in == rd_num_q))
                             ? bus.writeback_data_in : rd_dat_q;

  assign bus.imem_addr   = pc_q;
  assign bus.IR_out      = ir_q;
  assign bus.PC_out      = pcout_q;
  assign bus.update_1out = !rst && (state_q == S_RUN);
  assign bus.rst_p_out   = rst_p;
  assign bus.state_out   = state_q;

endmodule

// File: tb/tb_pipeline_frontend_ctrl.sv
// Scoreboard bench for pipeline_frontend_ctrl: directed scenarios then random traffic.
// Expected outputs come from a cycle-level behavioural model of the front end.
// Driver pushes expectations at each falling edge; a monitor compares them shortly after.
module tb_pipeline_frontend_ctrl;
  import pipeline_pkg::*;

  typedef struct {
    logic        rst;
    logic [2:0]  rm1, rn1, rd2;
    logic        loads;
    logic [2:0]  rm2, rn2;
    logic [15:0] d_rm, d_rn, d_rd;
    logic [15:0] res3;
    logic [2:0]  wn3;
    logic        w3;
    logic [15:0] wb;
    logic [2:0]  wn;
    logic        w;
    logic        br;
    logic [7:0]  tgt;
    logic        halt;
  } stim_t;

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [15:0] ir;
    logic [7:0]  pcout;
    logic        upd;
    logic [3:0]  rstp;
    logic [1:0]  st;
    logic [15:0] f_rm, f_rn, f_rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_frontend_ctrl_if bus ();
  pipeline_frontend_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  logic [15:0] mem [256];
  assign bus.imem_rdata = mem[bus.imem_addr];

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: mode 0=run 1=stall 2=flush 3=halt.
  int          m_mode, m_pc, m_pcout;
  logic [15:0] m_ir;
  logic [2:0]  m_rdnum;
  logic [15:0] m_rddat;

  task automatic chk(input string name, input int c, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, got, want);
    end
  endtask

  function automatic logic [15:0] bypass(input logic [2:0] num, input logic [15:0] raw, input stim_t s);
`ifdef FRONTEND_FWD_EN
    if (s.w3 && s.wn3 == num) return s.res3;
    if (s.w && s.wn == num) return s.wb;
`endif
    return raw;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b0, rm1: 3'd0, rn1: 3'd1, rd2: 3'd7, loads: 1'b0, rm2: 3'd4, rn2: 3'd5,
          d_rm: 16'h1111, d_rn: 16'h2222, d_rd: 16'h3333, res3: 16'h4444, wn3: 3'd6, w3: 1'b0,
          wb: 16'h5555, wn: 3'd6, w: 1'b0, br: 1'b0, tgt: 8'h00, halt: 1'b0};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rst                   = s.rst;
    bus.num_Rm_1in        = s.rm1;
    bus.num_Rn_1in        = s.rn1;
    bus.num_Rd_2in        = s.rd2;
    bus.loads_2in         = s.loads;
    bus.num_Rm_2in        = s.rm2;
    bus.num_Rn_2in        = s.rn2;
    bus.data_Rm_2in       = s.d_rm;
    bus.data_Rn_2in       = s.d_rn;
    bus.data_Rd_2in       = s.d_rd;
    bus.result_3in        = s.res3;
    bus.writenum_3in      = s.wn3;
    bus.write_3in         = s.w3;
    bus.writeback_data_in = s.wb;
    bus.writenum_in       = s.wn;
    bus.write_in          = s.w;
    bus.branch_taken_in   = s.br;
    bus.branch_target_in  = s.tgt;
    bus.halt_in           = s.halt;
  endtask

  // One clock cycle: apply inputs, record what this cycle must show, then
  // step the model across the coming rising edge.
  task automatic apply(input stim_t s);
    exp_t e;
    bit   s2_hit, stall_req, restall;
    int   nxt;
    @(negedge clk);
    drive(s);
    cyc++;
    if (s.rst) begin
      m_mode = 0; m_pc = 0; m_pcout = 0; m_ir = 16'h0000; m_rdnum = 3'd0; m_rddat = 16'h0000;
    end
    e.cyc   = cyc;
    e.addr  = 8'(m_pc);
    e.ir    = m_ir;
    e.pcout = 8'(m_pcout);
    e.upd   = !s.rst && m_mode == 0;
    e.st    = 2'(m_mode);
    if (s.rst)            e.rstp = 4'b1111;
    else if (m_mode == 1) e.rstp = 4'b0010;
    else if (m_mode == 2) e.rstp = 4'b0111;
    else if (m_mode == 3) e.rstp = 4'b0001;
    else                  e.rstp = 4'b0000;
    e.f_rm = bypass(s.rm2, s.d_rm, s);
    e.f_rn = bypass(s.rn2, s.d_rn, s);
    e.f_rd = m_rddat;
`ifdef FRONTEND_FWD_EN
    if (s.w && s.wn == m_rdnum) e.f_rd = s.wb;
`endif
    q.push_back(e);
    if (s.rst) return;

    s2_hit = (s.rd2 == s.rm1) || (s.rd2 == s.rn1);
`ifdef FRONTEND_FWD_EN
    stall_req = s.loads && s2_hit;
    restall   = 1'b0;
`else
    stall_req = s2_hit || (s.w3 && (s.wn3 == s.rm1 || s.wn3 == s.rn1));
    restall   = 1'b1;
`endif
    case (m_mode)
      0:       nxt = s.br ? 2 : stall_req ? 1 : s.halt ? 3 : 0;
      1:       nxt = s.br ? 2 : (stall_req && restall) ? 1 : s.halt ? 3 : 0;
      2:       nxt = s.halt ? 3 : 0;
      default: nxt = 3;
    endcase
    if (m_mode == 2) begin
      m_rdnum = 3'd0; m_rddat = 16'h0000;
    end else begin
      m_rdnum = s.rd2; m_rddat = bypass(s.rd2, s.d_rd, s);
    end
    if (nxt == 2) begin
      m_pc = int'(s.tgt); m_ir = 16'h0000;
    end else if (nxt == 0) begin
      m_ir = mem[m_pc]; m_pcout = m_pc; m_pc = (m_pc + 1) % 256;
    end
    m_mode = nxt;
  endtask

  // Monitor: compares every cycle's outputs against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("imem_addr",     e.cyc, 16'(bus.imem_addr),   16'(e.addr));
        chk("IR_out",        e.cyc, bus.IR_out,           e.ir);
        chk("PC_out",        e.cyc, 16'(bus.PC_out),      16'(e.pcout));
        chk("update_1out",   e.cyc, 16'(bus.update_1out), 16'(e.upd));
        chk("rst_p_out",     e.cyc, 16'(bus.rst_p_out),   16'(e.rstp));
        chk("state_out",     e.cyc, 16'(bus.state_out),   16'(e.st));
        chk("data_fRm_2out", e.cyc, bus.data_fRm_2out,    e.f_rm);
        chk("data_fRn_2out", e.cyc, bus.data_fRn_2out,    e.f_rn);
        chk("data_fRd_3out", e.cyc, bus.data_fRd_3out,    e.f_rd);
      end
    end
  end

  initial begin
    stim_t s;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    s = idle(); s.rst = 1'b1;
    drive(s);
    m_mode = 0; m_pc = 0; m_pcout = 0; m_ir = 16'h0000; m_rdnum = 3'd0; m_rddat = 16'h0000;

    // reset, then hazard-free fetch of 0,1,2,3
    apply(s); apply(s);
    for (int i = 0; i < 4; i++) apply(idle());
    // load-use stall
    s = idle(); s.loads = 1'b1; s.rd2 = 3'd3; s.rm1 = 3'd3;
    apply(s); apply(idle()); apply(idle());
    // branch together with a load-use: flush wins
    s.br = 1'b1; s.tgt = 8'h40;
    apply(s); apply(idle()); apply(idle());
    // S3 and S4 both writing r2; S3 is younger
    s = idle(); s.w3 = 1'b1; s.wn3 = 3'd2; s.res3 = 16'hBEEF;
    s.w = 1'b1; s.wn = 3'd2; s.wb = 16'hCAFE; s.rm2 = 3'd2; s.d_rm = 16'h1234;
    s.rn2 = 3'd2; s.d_rd = 16'h7777; s.rd2 = 3'd2;
    apply(s); s.w3 = 1'b0; apply(s); apply(idle());
    // PC wrap 0xFF -> 0x00
    s = idle(); s.br = 1'b1; s.tgt = 8'hFE;
    apply(s);
    for (int i = 0; i < 4; i++) apply(idle());
    // dependency held for several cycles
    s = idle(); s.rd2 = 3'd1;
    for (int i = 0; i < 3; i++) apply(s);
    apply(idle()); apply(idle());
    // reset arriving during a stall, then during a flush
    s = idle(); s.loads = 1'b1; s.rd2 = 3'd0;
    apply(s); s = idle(); s.rst = 1'b1; apply(s); apply(idle()); apply(idle());
    s = idle(); s.br = 1'b1; s.tgt = 8'h80;
    apply(s); s = idle(); s.rst = 1'b1; apply(s); apply(idle()); apply(idle());
    // halt holds for ten cycles; only reset leaves it
    s = idle(); s.halt = 1'b1;
    apply(s);
    for (int i = 0; i < 10; i++) apply(idle());
    s = idle(); s.rst = 1'b1; apply(s); apply(idle()); apply(idle());

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      s.rst   = ($urandom_range(0, 63) == 0);
      s.rm1   = 3'($urandom_range(0, 7));
      s.rn1   = 3'($urandom_range(0, 7));
      s.rd2   = 3'($urandom_range(0, 7));
      s.loads = ($urandom_range(0, 3) == 0);
      s.rm2   = 3'($urandom_range(0, 7));
      s.rn2   = 3'($urandom_range(0, 7));
      s.d_rm  = 16'($urandom);
      s.d_rn  = 16'($urandom);
      s.d_rd  = 16'($urandom);
      s.res3  = 16'($urandom);
      s.wn3   = 3'($urandom_range(0, 7));
      s.w3    = ($urandom_range(0, 2) == 0);
      s.wb    = 16'($urandom);
      s.wn    = 3'($urandom_range(0, 7));
      s.w     = ($urandom_range(0, 1) == 0);
      s.br    = ($urandom_range(0, 11) == 0);
      s.tgt   = 8'($urandom);
      s.halt  = ($urandom_range(0, 199) == 0);
      apply(s);
    end

    repeat (2) @(negedge clk);
    #4;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d expected=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
